// File: rtl/game_state_ctl.sv
// game_state_ctl: title/play/hit/level-done/game-over/win sequencer with lives and frame-timed freezes.
// Optional post-respawn invulnerability is built when RESPAWN_GRACE_EN is defined.
//   state      | meaning
//   IDLE       | title screen, waiting for start
//   PLAY       | hero and enemies running
//   HIT        | frozen after a collision
//   LEVEL_DONE | frozen after reaching the goal
//   GAME_OVER  | no lives left, waiting for start
//   WIN        | last level completed, waiting for start
module game_state_ctl #(
  parameter int LIVES        = 3,
  parameter int HIT_FRAMES   = 60,
  parameter int LEVEL_FRAMES = 90,
  parameter int LAST_LEVEL   = 10,
  parameter int GRACE_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       btn_start,
  input  logic       player_collision,
  input  logic       level_done,
  input  logic [9:0] level,
  output logic [2:0] game_state,
  output logic [2:0] lives,
  output logic       run_en,
  output logic       hero_rst,
  output logic       game_rst,
  output logic       invuln
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PLAY       = 3'd1,
    S_HIT        = 3'd2,
    S_LEVEL_DONE = 3'd3,
    S_GAME_OVER  = 3'd4,
    S_WIN        = 3'd5
  } state_e;

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);
  localparam logic [7:0] HIT_CNT    = 8'(HIT_FRAMES);
  localparam logic [7:0] LEVEL_CNT  = 8'(LEVEL_FRAMES);
  localparam logic [9:0] LAST_LVL   = 10'(LAST_LEVEL);

  state_e     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       vsync_q, btn_q;
  logic       run_en_q, run_en_d;
  logic       hero_rst_q, hero_rst_d;
  logic       game_rst_q, game_rst_d;
  logic       grace_start;
  logic       invuln_int;
  logic       tick, start_edge;

  assign tick       = vsync_in & ~vsync_q;
  assign start_edge = btn_start & ~btn_q;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;
    hero_rst_d  = 1'b0;
    game_rst_d  = 1'b0;
    grace_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d    = S_PLAY;
          lives_d    = LIVES_INIT;
          hero_rst_d = 1'b1;
          game_rst_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (level_done) begin
          state_d     = (level >= LAST_LVL) ? S_WIN : S_LEVEL_DONE;
          frame_cnt_d = LEVEL_CNT;
        end else if (player_collision && !invuln_int) begin
          state_d     = S_HIT;
          frame_cnt_d = HIT_CNT;
          lives_d     = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
        end
      end
      S_HIT: begin
        if (tick) begin
          if (frame_cnt_q <= 8'd1) begin
            frame_cnt_d = 8'd0;
            if (lives_q == 3'd0) begin
              state_d = S_GAME_OVER;
            end else begin
              state_d     = S_PLAY;
              hero_rst_d  = 1'b1;
              grace_start = 1'b1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end
        end
      end
      S_LEVEL_DONE: begin
        if (tick) begin
          if (frame_cnt_q <= 8'd1) begin
            frame_cnt_d = 8'd0;
            state_d     = S_PLAY;
            hero_rst_d  = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end
        end
      end
      S_GAME_OVER, S_WIN: begin
        if (start_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    run_en_d = (state_d == S_PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lives_q     <= 3'd0;
      frame_cnt_q <= 8'd0;
      vsync_q     <= 1'b0;
      btn_q       <= 1'b0;
      run_en_q    <= 1'b0;
      hero_rst_q  <= 1'b0;
      game_rst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      frame_cnt_q <= frame_cnt_d;
      vsync_q     <= vsync_in;
      btn_q       <= btn_start;
      run_en_q    <= run_en_d;
      hero_rst_q  <= hero_rst_d;
      game_rst_q  <= game_rst_d;
    end
  end

`ifdef RESPAWN_GRACE_EN
  localparam logic [7:0] GRACE_CNT = 8'(GRACE_FRAMES);

  logic [7:0] grace_cnt_q, grace_cnt_d;
  logic       invuln_q, invuln_d;

  // The window only runs while the next state is PLAY; any exit wipes it.
  always_comb begin
    grace_cnt_d = grace_cnt_q;
    invuln_d    = invuln_q;
    if (state_d != S_PLAY) begin
      grace_cnt_d = 8'd0;
      invuln_d    = 1'b0;
    end else if (grace_start) begin
      grace_cnt_d = GRACE_CNT;
      invuln_d    = (GRACE_CNT != 8'd0);
    end else if (tick && (grace_cnt_q != 8'd0)) begin
      grace_cnt_d = grace_cnt_q - 8'd1;
      invuln_d    = (grace_cnt_q != 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grace_cnt_q <= 8'd0;
      invuln_q    <= 1'b0;
    end else begin
      grace_cnt_q <= grace_cnt_d;
      invuln_q    <= invuln_d;
    end
  end

  assign invuln_int = invuln_q;
`else
  logic unused_grace;
  assign unused_grace = ^{grace_start, 32'(GRACE_FRAMES)};
  assign invuln_int   = 1'b0;
`endif

  assign game_state = state_q;
  assign lives      = lives_q;
  assign run_en     = run_en_q;
  assign hero_rst   = hero_rst_q;
  assign game_rst   = game_rst_q;
  assign invuln     = invuln_int;

endmodule

// File: tb/tb_game_state_ctl.sv
// Bench for game_state_ctl: directed flow plus random stimulus against a frame/lives reference model.
module tb_game_state_ctl;

  localparam int LIVES = 2, HIT_F = 3, LEVEL_F = 2, LAST_LVL = 2, GRACE_F = 2;
`ifdef RESPAWN_GRACE_EN
  localparam bit GRACE_ON = 1'b1;
`else
  localparam bit GRACE_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync_in = 1'b0;
  logic       btn_start = 1'b0;
  logic       player_collision = 1'b0;
  logic       level_done = 1'b0;
  logic [9:0] level = 10'd0;
  logic [2:0] game_state, lives;
  logic       run_en, hero_rst, game_rst, invuln;

  int nvec = 0;
  int nerr = 0;

  // model state: plain ints counting remaining lives/ticks
  int m_state = 0, m_lives = 0, m_frames = 0, m_grace = 0;
  bit m_invuln = 0, m_hero = 0, m_game = 0, m_vs = 0, m_btn = 0;

  game_state_ctl #(
    .LIVES(LIVES), .HIT_FRAMES(HIT_F), .LEVEL_FRAMES(LEVEL_F),
    .LAST_LEVEL(LAST_LVL), .GRACE_FRAMES(GRACE_F)
  ) dut (
    .clk(clk), .rst(rst), .vsync_in(vsync_in), .btn_start(btn_start),
    .player_collision(player_collision), .level_done(level_done), .level(level),
    .game_state(game_state), .lives(lives), .run_en(run_en),
    .hero_rst(hero_rst), .game_rst(game_rst), .invuln(invuln)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit tick, se;
    tick   = vsync_in && !m_vs;
    se     = btn_start && !m_btn;
    m_hero = 0;
    m_game = 0;
    if (rst) begin
      m_state = 0; m_lives = 0; m_frames = 0; m_grace = 0; m_invuln = 0;
      m_vs = 0; m_btn = 0;
    end else begin
      case (m_state)
        0: if (se) begin
          m_state = 1; m_lives = LIVES; m_hero = 1; m_game = 1;
        end
        1: begin
          if (level_done) begin
            m_state  = (int'(level) >= LAST_LVL) ? 5 : 3;
            m_frames = LEVEL_F;
          end else if (player_collision && !m_invuln) begin
            m_state  = 2;
            m_frames = HIT_F;
            if (m_lives > 0) m_lives--;
          end else if (tick && m_grace > 0) begin
            m_grace--;
            if (m_grace == 0) m_invuln = 0;
          end
        end
        2: if (tick) begin
          m_frames--;
          if (m_frames == 0) begin
            if (m_lives == 0) m_state = 4;
            else begin
              m_state = 1;
              m_hero  = 1;
              if (GRACE_ON) begin m_grace = GRACE_F; m_invuln = 1; end
            end
          end
        end
        3: if (tick) begin
          m_frames--;
          if (m_frames == 0) begin m_state = 1; m_hero = 1; end
        end
        default: if (se) m_state = 0;
      endcase
      if (m_state != 1) begin m_grace = 0; m_invuln = 0; end
      m_vs  = vsync_in;
      m_btn = btn_start;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("game_state", 32'(game_state), 32'(m_state));
    chk("lives", 32'(lives), 32'(m_lives));
    chk("run_en", 32'(run_en), 32'(m_state == 1));
    chk("hero_rst", 32'(hero_rst), 32'(m_hero));
    chk("game_rst", 32'(game_rst), 32'(m_game));
    chk("invuln", 32'(invuln), 32'(m_invuln));
  endtask

  task automatic frame();
    vsync_in = 1'b1; cycle();
    vsync_in = 1'b0; cycle();
  endtask

  initial begin
    // reset then start
    rst = 1'b1; cycle(); cycle();
    chk("rst_state", 32'(game_state), 32'd0);
    chk("rst_lives", 32'(lives), 32'd0);
    rst = 1'b0; cycle();
    btn_start = 1'b1; cycle();
    chk("start_state", 32'(game_state), 32'd1);
    chk("start_lives", 32'(lives), 32'd2);
    chk("start_game_rst", 32'(game_rst), 32'd1);
    chk("start_hero_rst", 32'(hero_rst), 32'd1);
    btn_start = 1'b0; cycle();
    chk("start_game_rst_off", 32'(game_rst), 32'd0);

    // first collision
    player_collision = 1'b1; cycle();
    chk("hit_state", 32'(game_state), 32'd2);
    chk("hit_lives", 32'(lives), 32'd1);
    chk("hit_run_en", 32'(run_en), 32'd0);
    player_collision = 1'b0;
    frame(); frame();
    vsync_in = 1'b1; cycle();
    chk("respawn_state", 32'(game_state), 32'd1);
    chk("respawn_hero_rst", 32'(hero_rst), 32'd1);
    vsync_in = 1'b0; cycle();

    // second collision, through grace window when built with it
    player_collision = 1'b1;
    if (GRACE_ON) begin
      chk("grace_invuln", 32'(invuln), 32'd1);
      frame();
      vsync_in = 1'b1; cycle();
      chk("grace_state", 32'(game_state), 32'd1);
      chk("grace_lives", 32'(lives), 32'd1);
      chk("grace_end_invuln", 32'(invuln), 32'd0);
      cycle();
      vsync_in = 1'b0;
    end else begin
      chk("no_grace_invuln", 32'(invuln), 32'd0);
      cycle();
    end
    chk("last_state", 32'(game_state), 32'd2);
    chk("last_lives", 32'(lives), 32'd0);
    player_collision = 1'b0;
    frame(); frame(); frame();
    chk("game_over", 32'(game_state), 32'd4);
    btn_start = 1'b1; cycle();
    chk("over_to_idle", 32'(game_state), 32'd0);
    btn_start = 1'b0; cycle();

    // level complete, simultaneous events, win
    btn_start = 1'b1; cycle(); btn_start = 1'b0; cycle();
    level = 10'd1; level_done = 1'b1; cycle(); level_done = 1'b0;
    chk("lvl_state", 32'(game_state), 32'd3);
    chk("lvl_lives", 32'(lives), 32'd2);
    frame();
    vsync_in = 1'b1; cycle();
    chk("lvl_back_state", 32'(game_state), 32'd1);
    chk("lvl_back_hero_rst", 32'(hero_rst), 32'd1);
    vsync_in = 1'b0; cycle();
    level_done = 1'b1; player_collision = 1'b1; cycle();
    level_done = 1'b0; player_collision = 1'b0;
    chk("simul_state", 32'(game_state), 32'd3);
    chk("simul_lives", 32'(lives), 32'd2);
    frame(); frame();
    level = 10'd2; level_done = 1'b1; cycle(); level_done = 1'b0;
    chk("win_state", 32'(game_state), 32'd5);
    btn_start = 1'b1; cycle(); btn_start = 1'b0; cycle();

    // mid-game reset
    btn_start = 1'b1; cycle(); btn_start = 1'b0;
    rst = 1'b1; player_collision = 1'b1; cycle();
    chk("midrst_state", 32'(game_state), 32'd0);
    rst = 1'b0; player_collision = 1'b0; cycle();

    // random phase
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 199) == 0);
      vsync_in         = $urandom_range(0, 1) == 1;
      btn_start        = ($urandom_range(0, 9) == 0) ? ~btn_start : btn_start;
      player_collision = ($urandom_range(0, 5) == 0);
      level_done       = ($urandom_range(0, 15) == 0);
      level            = 10'($urandom_range(0, 3));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/game_state_ctl.md
# game_state_ctl

Top-level game sequencer for the pixel-clock domain. It owns the title → play → hit/level-complete → game-over/win flow and counts lives. It times freeze periods in video frames and drives the reset and enable strobes that gate hero control, enemy control and level management. It sits beside the level management unit and feeds the info panel and the overlay drawing stages.

## Interface
Parameters:
- LIVES, 3: lives loaded at game start; range 1..7.
- HIT_FRAMES, 60: frames frozen after a player collision.
- LEVEL_FRAMES, 90: frames frozen after a level is completed.
- LAST_LEVEL, 10: completing this level, or any higher level, means WIN.
- GRACE_FRAMES, 120: post-respawn invulnerability length. Used only with RESPAWN_GRACE_EN.

Ports:
- clk  in  1: pixel clock.
- rst  in  1: reset, synchronous, active-high.
- vsync_in  in  1: timing-chain vsync. Its rising edge marks a frame.
- btn_start  in  1: start button, already synchronous to clk. Level-sensitive; the block edge-detects it.
- player_collision  in  1: hero-enemy contact, level-sensitive.
- level_done  in  1: one-cycle pulse. The hero has reached the goal.
- level  in  10: current level number.
- game_state  out  3: IDLE=0, PLAY=1, HIT=2, LEVEL_DONE=3, GAME_OVER=4, WIN=5.
- lives  out  3: remaining lives.
- run_en  out  1: high only in PLAY. Gates the hero and enemy controllers.
- hero_rst  out  1: one-cycle pulse on every entry into PLAY.
- game_rst  out  1: one-cycle pulse on IDLE→PLAY only. Clears level and score.
- invuln  out  1: high while the respawn grace window is active.

## Operation
- Frame tick: vsync_in is registered, and tick = vsync_in & ~vsync_q. tick asserts for 1 cycle per frame.
- Start edge: start_edge = btn_start & ~btn_q.
- frame_cnt, 8 bits: loaded with HIT_FRAMES or LEVEL_FRAMES on entry to the matching state, and decremented on each tick. The state exits on the tick that takes frame_cnt from 1 to 0, so the state lasts exactly N ticks.
- IDLE:
  - start_edge → PLAY.
  - lives ← LIVES.
  - Pulse game_rst and hero_rst.
- PLAY:
  - level_done has priority over player_collision.
  - On level_done, with level ≥ LAST_LEVEL: → WIN.
  - On level_done otherwise: → LEVEL_DONE.
  - Else, if player_collision is high and invuln is low: → HIT, and lives ← lives−1 (saturating at 0).
- HIT: when the frame count expires:
  - lives == 0 → GAME_OVER.
  - Otherwise → PLAY and pulse hero_rst.
- LEVEL_DONE: when the frame count expires → PLAY and pulse hero_rst. lives is unchanged.
- GAME_OVER / WIN: start_edge → IDLE. All other inputs are ignored.
- Inputs outside the states that use them are ignored: level_done outside PLAY, and player_collision outside PLAY.
- A start_edge outside IDLE, GAME_OVER and WIN is ignored.

## Timing
- Reset values:
  - game_state=IDLE, lives=0, run_en=0, hero_rst=0, game_rst=0, invuln=0.
  - frame_cnt=0, grace_cnt=0.
  - The edge registers clear to 0.
- All outputs are registered.
- Input → state/output latency is 1 cycle. An input sampled at edge k is reflected in game_state, run_en, pulses and lives after edge k.
- run_en falls in the same cycle game_state leaves PLAY.
- hero_rst and game_rst are high for exactly one cycle, aligned with the first PLAY cycle.
- rst asserted mid-operation takes effect at the next edge and overrides every transition.
- vsync held high produces one tick only. A tick coinciding with a state entry is not counted toward the new state.

## Configuration
- Macro: RESPAWN_GRACE_EN.
- Defined:
  - On HIT→PLAY, grace_cnt ← GRACE_FRAMES and invuln=1.
  - grace_cnt decrements on each tick while in PLAY. invuln falls on the tick reaching 0.
  - Collisions are ignored while invuln=1.
  - IDLE→PLAY and LEVEL_DONE→PLAY do not start a grace window.
  - Leaving PLAY clears grace_cnt and invuln.
- Undefined: no grace logic; invuln is tied to 0 and GRACE_FRAMES is unused.

## Test plan
Bench parameters: LIVES=2, HIT_FRAMES=3, LEVEL_FRAMES=2, LAST_LEVEL=2, GRACE_FRAMES=2.
- Reset then start: rst for 2 cycles, then a btn_start 0→1 → next cycle game_state=1, lives=2, run_en=1, and hero_rst and game_rst each high for exactly 1 cycle.
- Collision: player_collision=1 in PLAY → next cycle game_state=2, lives=1, run_en=0. After 3 vsync rising edges → game_state=1 and hero_rst pulses.
- Last life: a second collision → lives=0, game_state=2. After 3 ticks → game_state=4. btn_start edge → game_state=0.
- Level complete:
  - level_done with level=1 → game_state=3, lives unchanged. After 2 ticks → PLAY with a hero_rst pulse.
  - level_done with level=2 → game_state=5.
- Simultaneous events: level_done and player_collision in the same cycle with level=1 → game_state=3, lives unchanged.
- Grace, built with RESPAWN_GRACE_EN:
  - After HIT→PLAY, invuln=1, and player_collision held high leaves lives and state unchanged for 2 ticks.
  - After the window ends, the next collision → HIT.
  - Built without the macro, invuln stays 0 throughout.
